sponge_absorb: RTL and testbench

SPONGE_ABSORB -- requirements
Module: sponge_absorb

---
 rtl/sponge_pkg.sv | 17 +
 rtl/sponge_pad.sv | 32 +++
 rtl/sponge_absorb.sv | 160 ++++++++++++++++
 tb/tb_sponge_absorb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sponge_pkg.sv
// Shared sponge definitions: absorb/squeeze FSM states and the pad10* bit-position helper.
package sponge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    PAD_BLK,
    PERM,
    DONE
  } sponge_state_t;

  // Position of the single '1' pad bit after nbits message bits; a full block pads at the MSB of the next block.
  function automatic int unsigned pad_bit_pos(input int unsigned rwidth, input int unsigned nbits);
    return (nbits >= rwidth) ? rwidth - 1 : rwidth - 1 - nbits;
  endfunction

endpackage

// File: rtl/sponge_pad.sv
// Combinational pad10* for the final rate block; flags a full final block that needs an extra padding block.
module sponge_pad
  import sponge_pkg::*;
#(
  parameter int RWIDTH = 32,
  parameter int BW     = $clog2(RWIDTH + 1)
) (
  input  logic [RWIDTH-1:0] msg_data,
  input  logic [BW-1:0]     msg_bits,
  input  logic              msg_last,
  output logic [RWIDTH-1:0] padded,
  output logic              full
);

  logic [BW-1:0]     bits_clamped;
  logic [RWIDTH-1:0] keep_mask;
  logic [RWIDTH-1:0] pad_bit;

  // Oversized bit counts behave as a completely full block.
  assign bits_clamped = (msg_bits > BW'(RWIDTH)) ? BW'(RWIDTH) : msg_bits;
  assign keep_mask    = ~({RWIDTH{1'b1}} >> bits_clamped);
  assign pad_bit      = {{(RWIDTH-1){1'b0}}, 1'b1} << pad_bit_pos(RWIDTH, 32'(bits_clamped));
  assign full         = msg_last && (bits_clamped == BW'(RWIDTH));

  always_comb begin
    padded = msg_data;
    if (msg_last && !full) begin
      padded = (msg_data & keep_mask) | pad_bit;
    end
  end

endmodule

// File: rtl/sponge_absorb.sv
// Sponge absorb stage: XORs message blocks into the rate and drives an external permutation.
// Define SPONGE_ABSORB_PAD_EN to enable pad10* padding of the final block.
module sponge_absorb
  import sponge_pkg::*;
#(
  parameter int CWIDTH      = 320,
  parameter int RWIDTH      = 32,
  parameter int ROUND_COUNT = 10,
  parameter int REMAINWIDTH = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ROUND_COUNT-1:0]        rounds,
  input  logic [RWIDTH-1:0]             msg_data,
  input  logic                          msg_valid,
  input  logic                          msg_last,
  input  logic [$clog2(RWIDTH+1)-1:0]   msg_bits,
  output logic                          msg_ready,
  output logic                          perm_go,
  output logic [RWIDTH-1:0]             perm_r_in,
  output logic [CWIDTH-1:0]             perm_c_in,
  output logic [ROUND_COUNT-1:0]        perm_rounds,
  input  logic [RWIDTH-1:0]             perm_r_out,
  input  logic [CWIDTH-1:0]             perm_c_out,
  input  logic                          perm_done,
  output logic [RWIDTH-1:0]             r_out,
  output logic [CWIDTH-1:0]             c_out,
  output logic                          absorb_done,
  output logic                          busy,
  output logic [REMAINWIDTH-1:0]        block_count
);

  sponge_state_t           state_reg, state_next;
  logic [RWIDTH-1:0]       s_r_reg, s_r_next;
  logic [CWIDTH-1:0]       s_c_reg, s_c_next;
  logic [REMAINWIDTH-1:0]  count_reg, count_next;
  logic                    last_reg, last_next;
  logic                    pad_pend_reg, pad_pend_next;
  logic [RWIDTH-1:0]       r_out_reg, r_out_next;
  logic [CWIDTH-1:0]       c_out_reg, c_out_next;
  logic                    done_reg, done_next;

  logic [RWIDTH-1:0]       blk;
  logic                    blk_full;
  logic [RWIDTH-1:0]       pad_only_blk;

`ifdef SPONGE_ABSORB_PAD_EN
  sponge_pad #(.RWIDTH(RWIDTH)) u_pad (
    .msg_data (msg_data),
    .msg_bits (msg_bits),
    .msg_last (msg_last),
    .padded   (blk),
    .full     (blk_full)
  );
`else
  logic unused_msg_bits;
  assign unused_msg_bits = ^msg_bits;
  assign blk             = msg_data;
  assign blk_full        = 1'b0;
`endif

  // Extra block absorbed after a full final block: just the pad bit at the MSB.
  assign pad_only_blk = {{(RWIDTH-1){1'b0}}, 1'b1} << pad_bit_pos(RWIDTH, RWIDTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      s_r_reg      <= '0;
      s_c_reg      <= '0;
      count_reg    <= '0;
      last_reg     <= 1'b0;
      pad_pend_reg <= 1'b0;
      r_out_reg    <= '0;
      c_out_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      s_r_reg      <= s_r_next;
      s_c_reg      <= s_c_next;
      count_reg    <= count_next;
      last_reg     <= last_next;
      pad_pend_reg <= pad_pend_next;
      r_out_reg    <= r_out_next;
      c_out_reg    <= c_out_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    s_r_next      = s_r_reg;
    s_c_next      = s_c_reg;
    count_next    = count_reg;
    last_next     = last_reg;
    pad_pend_next = pad_pend_reg;
    r_out_next    = r_out_reg;
    c_out_next    = c_out_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          s_r_next      = '0;
          s_c_next      = '0;
          count_next    = '0;
          last_next     = 1'b0;
          pad_pend_next = 1'b0;
          state_next    = WAIT_BLK;
        end
      end
      WAIT_BLK: begin
        if (msg_valid) begin
          s_r_next      = s_r_reg ^ blk;
          last_next     = msg_last;
          pad_pend_next = blk_full;
          state_next    = PERM;
        end
      end
      PERM: begin
        if (perm_done) begin
          s_r_next   = perm_r_out;
          s_c_next   = perm_c_out;
          count_next = (&count_reg) ? count_reg : count_reg + 1'b1;
          if (!last_reg) begin
            state_next = WAIT_BLK;
          end else if (pad_pend_reg) begin
            state_next = PAD_BLK;
          end else begin
            state_next = DONE;
          end
        end
      end
      PAD_BLK: begin
        s_r_next      = s_r_reg ^ pad_only_blk;
        pad_pend_next = 1'b0;
        state_next    = PERM;
      end
      DONE: begin
        r_out_next = s_r_reg;
        c_out_next = s_c_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign msg_ready   = (state_reg == WAIT_BLK);
  assign perm_go     = (state_reg == PERM);
  assign perm_r_in   = s_r_reg;
  assign perm_c_in   = s_c_reg;
  assign perm_rounds = rounds;
  assign r_out       = r_out_reg;
  assign c_out       = c_out_reg;
  assign absorb_done = done_reg;
  assign busy        = (state_reg != IDLE);
  assign block_count = count_reg;

endmodule

// File: tb/tb_sponge_absorb.sv
// Directed self-checking bench for sponge_absorb with a stub permutation (r^A5A5A5A5, c+1, done on 3rd cycle).
module tb_sponge_absorb;

  localparam int CW  = 320;
  localparam int RW  = 32;
  localparam int RC  = 10;
  localparam int RMW = 20;
  localparam int BW  = $clog2(RW + 1);

`ifdef SPONGE_ABSORB_PAD_EN
  localparam logic [31:0] EXP_A_R = 32'hB79125A5;
  localparam logic [31:0] EXP_B_R = 32'h80000000;
  localparam logic [31:0] EXP_B_C = 32'd2;
  localparam logic [31:0] EXP_Z_R = 32'h25A5A5A5;
  localparam logic [31:0] EXP_3_R = 32'h5A25A5A6;
`else
  localparam logic [31:0] EXP_A_R = 32'hB791F3DD;
  localparam logic [31:0] EXP_B_R = 32'hA5A5A5A5;
  localparam logic [31:0] EXP_B_C = 32'd1;
  localparam logic [31:0] EXP_Z_R = 32'h5A5A5A5A;
  localparam logic [31:0] EXP_3_R = 32'h5AA5A5A6;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [RC-1:0]  rounds;
  logic [RW-1:0]  msg_data;
  logic           msg_valid;
  logic           msg_last;
  logic [BW-1:0]  msg_bits;
  logic           msg_ready;
  logic           perm_go;
  logic [RW-1:0]  perm_r_in;
  logic [CW-1:0]  perm_c_in;
  logic [RC-1:0]  perm_rounds;
  logic [RW-1:0]  perm_r_out;
  logic [CW-1:0]  perm_c_out;
  logic           perm_done;
  logic [RW-1:0]  r_out;
  logic [CW-1:0]  c_out;
  logic           absorb_done;
  logic           busy;
  logic [RMW-1:0] block_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int hs_total     = 0;
  int done_total   = 0;
  int perm_cnt     = 0;

  always #5 clk = ~clk;

  sponge_absorb #(.CWIDTH(CW), .RWIDTH(RW), .ROUND_COUNT(RC), .REMAINWIDTH(RMW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rounds      (rounds),
    .msg_data    (msg_data),
    .msg_valid   (msg_valid),
    .msg_last    (msg_last),
    .msg_bits    (msg_bits),
    .msg_ready   (msg_ready),
    .perm_go     (perm_go),
    .perm_r_in   (perm_r_in),
    .perm_c_in   (perm_c_in),
    .perm_rounds (perm_rounds),
    .perm_r_out  (perm_r_out),
    .perm_c_out  (perm_c_out),
    .perm_done   (perm_done),
    .r_out       (r_out),
    .c_out       (c_out),
    .absorb_done (absorb_done),
    .busy        (busy),
    .block_count (block_count)
  );

  // Stub permutation: result valid on the third cycle of perm_go.
  always @(posedge clk) perm_cnt <= perm_go ? perm_cnt + 1 : 0;
  assign perm_done  = perm_go && (perm_cnt == 2);
  assign perm_r_out = perm_r_in ^ 32'hA5A5A5A5;
  assign perm_c_out = perm_c_in + CW'(1);

  always @(posedge clk) begin
    if (msg_valid && msg_ready) hs_total <= hs_total + 1;
    if (absorb_done) done_total <= done_total + 1;
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_block(input string tag, input logic [RW-1:0] d, input logic last, input logic [BW-1:0] bits);
    int n = 0;
    msg_data  = d;
    msg_last  = last;
    msg_bits  = bits;
    msg_valid = 1'b1;
    while (!msg_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check({tag, "_ready_timeout"}, CW'(msg_ready), CW'(1));
    tick();
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!absorb_done && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, CW'(absorb_done), CW'(1));
  endtask

  task automatic run_single(input string tag, input logic [RW-1:0] d, input logic [BW-1:0] bits,
                            input logic [RW-1:0] er, input logic [31:0] ec, input logic [31:0] en,
                            input bit disturb);
    pulse_start();
    send_block(tag, d, 1'b1, bits);
    $display("[TB] %s: block %08h bits %0d accepted", tag, d, bits);
    check({tag, "_perm_go"}, CW'(perm_go), CW'(1));
    check({tag, "_ready_in_perm"}, CW'(msg_ready), CW'(0));
    check({tag, "_busy"}, CW'(busy), CW'(1));
    if (disturb) pulse_start();
    wait_done(tag);
    check({tag, "_r_out"}, CW'(r_out), CW'(er));
    check({tag, "_c_out"}, c_out, CW'(ec));
    check({tag, "_count"}, CW'(block_count), CW'(en));
    tick();
    check({tag, "_done_pulse"}, CW'(absorb_done), CW'(0));
    check({tag, "_idle"}, CW'(busy), CW'(0));
    check({tag, "_r_hold"}, CW'(r_out), CW'(er));
    $display("[TB] %s: r_out %08h c_out %0h count %0d", tag, r_out, c_out, block_count);
  endtask

  initial begin
    logic [RW-1:0] blks [3];
    int b, n, hs0, dn0;
    bit ph;

    reset     = 1'b0;
    start     = 1'b0;
    rounds    = RC'(10'h2A5);
    msg_data  = '0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_bits  = '0;
    tick();
    tick();
    check("rst_r_out", CW'(r_out), CW'(0));
    check("rst_c_out", c_out, CW'(0));
    check("rst_count", CW'(block_count), CW'(0));
    check("rst_ready", CW'(msg_ready), CW'(0));
    check("rst_perm_go", CW'(perm_go), CW'(0));
    check("rst_done", CW'(absorb_done), CW'(0));
    check("rst_busy", CW'(busy), CW'(0));
    check("rounds_fwd", CW'(perm_rounds), CW'(10'h2A5));
    reset = 1'b1;
    tick();
    check("idle_ready", CW'(msg_ready), CW'(0));

    run_single("half_block", 32'h12345678, BW'(16), EXP_A_R, 32'd1, 32'd1, 1'b0);
    run_single("full_block", 32'h00000000, BW'(32), EXP_B_R, EXP_B_C, EXP_B_C, 1'b0);
    run_single("bits_over", 32'h00000000, BW'(40), EXP_B_R, EXP_B_C, EXP_B_C, 1'b0);
    run_single("bits_zero", 32'hFFFFFFFF, BW'(0), EXP_Z_R, 32'd1, 32'd1, 1'b0);
    run_single("start_busy", 32'h12345678, BW'(16), EXP_A_R, 32'd1, 32'd1, 1'b1);

    // Three blocks with msg_valid toggling every cycle.
    blks[0] = 32'h00000001;
    blks[1] = 32'h00000002;
    blks[2] = 32'hFF000000;
    pulse_start();
    hs0 = hs_total;
    dn0 = done_total;
    b   = 0;
    n   = 0;
    ph  = 1'b1;
    while (b < 3 && n < 300) begin
      msg_data  = blks[b];
      msg_last  = (b == 2);
      msg_bits  = BW'(8);
      msg_valid = ph;
      if (ph && msg_ready) begin
        $display("[TB] three_blk: block %0d %08h accepted", b, blks[b]);
        b++;
      end
      tick();
      ph = ~ph;
      n++;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    check("three_blk_sent", CW'(b), CW'(3));
    wait_done("three_blk");
    check("three_blk_r_out", CW'(r_out), CW'(EXP_3_R));
    check("three_blk_c_out", c_out, CW'(3));
    check("three_blk_count", CW'(block_count), CW'(3));
    tick();
    tick();
    check("three_blk_hs", CW'(hs_total - hs0), CW'(3));
    check("three_blk_pulses", CW'(done_total - dn0), CW'(1));
    check("three_blk_idle", CW'(busy), CW'(0));
    $display("[TB] three_blk: r_out %08h count %0d", r_out, block_count);

    // Reset asserted during the permutation of the second block.
    pulse_start();
    send_block("rst_mid", 32'hDEADBEEF, 1'b0, BW'(0));
    send_block("rst_mid", 32'hCAFEF00D, 1'b0, BW'(0));
    tick();
    check("rst_mid_in_perm", CW'(perm_go), CW'(1));
    reset = 1'b0;
    #1;
    check("rst_mid_r_out", CW'(r_out), CW'(0));
    check("rst_mid_c_out", c_out, CW'(0));
    check("rst_mid_count", CW'(block_count), CW'(0));
    check("rst_mid_perm_go", CW'(perm_go), CW'(0));
    check("rst_mid_ready", CW'(msg_ready), CW'(0));
    check("rst_mid_busy", CW'(busy), CW'(0));
    check("rst_mid_done", CW'(absorb_done), CW'(0));
    check("rst_mid_perm_r", CW'(perm_r_in), CW'(0));
    $display("[TB] rst_mid: reset applied during block 2 permutation");
    tick();
    reset = 1'b1;
    tick();
    run_single("after_rst", 32'h12345678, BW'(16), EXP_A_R, 32'd1, 32'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
